// File: rtl/present_pkg.sv
// present_pkg: PRESENT S-box, bit permutation, key-schedule steps and FSM state type
package present_pkg;
    localparam int BLOCK_W = 64;
    localparam int ROUND_KEY_W = 64;
    localparam logic [63:0] SBOX_TAB = 64'h2174_8FE3_DA09_B65C;
    localparam logic [63:0] INV_SBOX_TAB = 64'hA970_364B_D21C_8FE5;

    typedef enum logic [1:0] {IDLE, KEYFWD, ROUND, FINAL} state_e;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX_TAB[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        return INV_SBOX_TAB[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [BLOCK_W-1:0] sbox_layer(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        for (int n = 0; n < 16; n++) y[6'(4 * n) +: 4] = sbox(x[6'(4 * n) +: 4]);
        return y;
    endfunction

    function automatic logic [BLOCK_W-1:0] inv_sbox_layer(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        for (int n = 0; n < 16; n++) y[6'(4 * n) +: 4] = inv_sbox(x[6'(4 * n) +: 4]);
        return y;
    endfunction

    function automatic logic [BLOCK_W-1:0] p_layer(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        y[63] = x[63];
        for (int i = 0; i < 63; i++) y[6'((i * 16) % 63)] = x[6'(i)];
        return y;
    endfunction

    function automatic logic [BLOCK_W-1:0] inv_p_layer(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        y[63] = x[63];
        for (int i = 0; i < 63; i++) y[6'(i)] = x[6'((i * 16) % 63)];
        return y;
    endfunction

    function automatic logic [79:0] key_fwd80(input logic [79:0] k, input logic [4:0] i);
        logic [79:0] r;
        r = {k[18:0], k[79:19]};
        r[79:76] = sbox(r[79:76]);
        r[19:15] = r[19:15] ^ i;
        return r;
    endfunction

    function automatic logic [79:0] key_inv80(input logic [79:0] k, input logic [4:0] i);
        logic [79:0] r;
        r = k;
        r[19:15] = r[19:15] ^ i;
        r[79:76] = inv_sbox(r[79:76]);
        return {r[60:0], r[79:61]};
    endfunction

    function automatic logic [127:0] key_fwd128(input logic [127:0] k, input logic [4:0] i);
        logic [127:0] r;
        r = {k[66:0], k[127:67]};
        r[127:124] = sbox(r[127:124]);
        r[123:120] = sbox(r[123:120]);
        r[66:62] = r[66:62] ^ i;
        return r;
    endfunction

    function automatic logic [127:0] key_inv128(input logic [127:0] k, input logic [4:0] i);
        logic [127:0] r;
        r = k;
        r[66:62] = r[66:62] ^ i;
        r[127:124] = inv_sbox(r[127:124]);
        r[123:120] = inv_sbox(r[123:120]);
        return {r[60:0], r[127:61]};
    endfunction
endpackage

// File: rtl/present_key_sched.sv
// present_key_sched: PRESENT key register with forward/inverse schedule step (80- or 128-bit keys)
module present_key_sched
    import present_pkg::*;
#(
    parameter int KEY_W = 80
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [KEY_W-1:0]       load_key,
    input  logic                   step,
    input  logic                   inv,
    input  logic [4:0]             cnt,
    output logic [ROUND_KEY_W-1:0] round_key
`ifdef PRESENT_KEY_CACHE_EN
    ,
    output logic [KEY_W-1:0]       key
`endif
);
    logic [KEY_W-1:0] key_q, key_d, fwd_key, inv_key;

    if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
        $error("present_key_sched: KEY_W must be 80 or 128");
    end

    if (KEY_W == 128) begin : g_k128
        assign fwd_key = key_fwd128(key_q, cnt);
        assign inv_key = key_inv128(key_q, cnt);
    end else begin : g_k80
        assign fwd_key = key_fwd80(key_q, cnt);
        assign inv_key = key_inv80(key_q, cnt);
    end

    always_comb key_d = load ? load_key : step ? (inv ? inv_key : fwd_key) : key_q;

    always_ff @(posedge clk) key_q <= !rst ? '0 : key_d;

    assign round_key = key_q[KEY_W-1 -: ROUND_KEY_W];
`ifdef PRESENT_KEY_CACHE_EN
    assign key = key_q;
`endif
endmodule

// File: rtl/present_cipher_param.sv
// present_cipher_param: iterative PRESENT-80/128 encrypt/decrypt core; PRESENT_KEY_CACHE_EN adds a decrypt key cache
module present_cipher_param
    import present_pkg::*;
#(
    parameter int KEY_W  = 80,
    parameter int ROUNDS = 31
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               decrypt,
    input  logic [BLOCK_W-1:0] plain_text,
    input  logic [KEY_W-1:0]   master_key,
    output logic [BLOCK_W-1:0] out,
    output logic               done,
    output logic               busy
);
    localparam logic [4:0] LAST = 5'(ROUNDS);

    state_e state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [BLOCK_W-1:0] blk_q, blk_d, out_q, out_d;
    logic dec_q, dec_d, done_q, done_d, busy_q, busy_d;
    logic key_load, key_step, hit;
    logic [KEY_W-1:0] key_init;
    logic [ROUND_KEY_W-1:0] rk;

    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
        $error("present_cipher_param: ROUNDS must be 1..31");
    end

`ifdef PRESENT_KEY_CACHE_EN
    logic [KEY_W-1:0] key, cache_key_q, cache_key_d, cache_kn_q, cache_kn_d;
    logic cache_v_q, cache_v_d;
    assign hit = cache_v_q && master_key == cache_key_q;
    assign key_init = hit ? cache_kn_q : master_key;
    // first decrypt round sees K_(ROUNDS+1); FINAL of a decrypt sees the master key again
    always_comb begin
        cache_kn_d = state_q == ROUND && dec_q && cnt_q == LAST ? key : cache_kn_q;
        cache_key_d = state_q == FINAL && dec_q ? key : cache_key_q;
        cache_v_d = cache_v_q || (state_q == FINAL && dec_q);
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            cache_kn_q <= '0;
            cache_key_q <= '0;
            cache_v_q <= 1'b0;
        end else begin
            cache_kn_q <= cache_kn_d;
            cache_key_q <= cache_key_d;
            cache_v_q <= cache_v_d;
        end
    end
`else
    assign hit = 1'b0;
    assign key_init = master_key;
`endif

    present_key_sched #(.KEY_W(KEY_W)) u_key (
        .clk(clk),
        .rst(rst),
        .load(key_load),
        .load_key(key_init),
        .step(key_step),
        .inv(state_q == ROUND && dec_q),
        .cnt(cnt_q),
        .round_key(rk)
`ifdef PRESENT_KEY_CACHE_EN
        ,
        .key(key)
`endif
    );

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        blk_d = blk_q;
        dec_d = dec_q;
        out_d = out_q;
        done_d = 1'b0;
        busy_d = busy_q;
        key_load = 1'b0;
        key_step = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = decrypt && !hit ? KEYFWD : ROUND;
                cnt_d = decrypt && hit ? LAST : 5'd1;
                blk_d = plain_text;
                dec_d = decrypt;
                busy_d = 1'b1;
                key_load = 1'b1;
            end
            KEYFWD: begin
                key_step = 1'b1;
                state_d = cnt_q == LAST ? ROUND : KEYFWD;
                cnt_d = cnt_q == LAST ? cnt_q : cnt_q + 5'd1;
            end
            ROUND: begin
                key_step = 1'b1;
                blk_d = dec_q ? inv_sbox_layer(inv_p_layer(blk_q ^ rk)) : p_layer(sbox_layer(blk_q ^ rk));
                state_d = (dec_q ? cnt_q == 5'd1 : cnt_q == LAST) ? FINAL : ROUND;
                cnt_d = state_d == FINAL ? cnt_q : dec_q ? cnt_q - 5'd1 : cnt_q + 5'd1;
            end
            default: begin
                out_d = blk_q ^ rk;
                done_d = 1'b1;
                busy_d = 1'b0;
                state_d = IDLE;
                cnt_d = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            blk_q <= '0;
            dec_q <= 1'b0;
            out_q <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            blk_q <= blk_d;
            dec_q <= dec_d;
            out_q <= out_d;
            done_q <= done_d;
            busy_q <= busy_d;
        end
    end

    assign out = out_q;
    assign done = done_q;
    assign busy = busy_q;
endmodule
